hd44780_rd: RTL and testbench

- Read-cycle engine for the HD44780 character LCD, running on the 50 MHz board clock; complement to the existing LCD write path.
- Performs single reads of the busy flag/address counter (RS=0) or DDRAM/CGRAM data (RS=1).
- Optional poll mode repeats busy-flag reads until BF clears or a poll limit is reached.
- The top-level bus mux gives this block the LCD pins while `active` is high and tristates the FPGA data drivers.

---
 rtl/hd44780_rd.sv | 143 ++++++++++++++
 tb/tb_hd44780_rd.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/hd44780_rd.sv
// rtl/hd44780_rd.sv - HD44780 read-cycle engine: single BF/AC or data-RAM reads, optional busy-flag polling
module hd44780_rd #(
  parameter int          T_AS     = 3,
  parameter int          T_EH     = 25,
  parameter int          T_AH     = 1,
  parameter int          T_EL     = 24,
  parameter logic [15:0] POLL_MAX = 16'd5000
) (
  input  logic       clkIn,
  input  logic       rstIn_n,
  input  logic       req,
  input  logic       rs_sel,
  input  logic       poll,
  output logic       active,
  output logic       done,
  output logic       timeout,
  output logic [7:0] rdata,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  input  logic [7:0] lcd_db_in
);

  typedef enum logic [2:0] {IDLE, SETUP, EHIGH, HOLD, RECOVER} state_t;

  localparam logic [15:0] AS_LAST = 16'(T_AS - 1);
  localparam logic [15:0] EH_LAST = 16'(T_EH - 1);
  localparam logic [15:0] AH_LAST = 16'(T_AH - 1);
  localparam logic [15:0] EL_LAST = 16'(T_EL - 1);

  state_t      state_q, state_d;
  logic [15:0] tmr_q, tmr_d;
  logic [15:0] pcnt_q, pcnt_d;
  logic        rs_q, rs_d;
  logic        poll_q, poll_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        active_q, active_d;
  logic        done_q, done_d;
  logic        timeout_q, timeout_d;
  logic        e_q, e_d;
  logic        lrs_q, lrs_d;
  logic        rw_q, rw_d;

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q + 16'd1;
    pcnt_d    = pcnt_q;
    rs_d      = rs_q;
    poll_d    = poll_q;
    rdata_d   = rdata_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        tmr_d = 16'd0;
        // The done cycle still belongs to the finishing transaction, so req is not taken then.
        if (req && !done_q) begin
          rs_d    = rs_sel;
          poll_d  = poll & ~rs_sel;
          pcnt_d  = 16'd0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (tmr_q == AS_LAST) begin
          tmr_d   = 16'd0;
          state_d = EHIGH;
        end
      end
      EHIGH: begin
        if (tmr_q == EH_LAST) begin
          rdata_d = lcd_db_in;
          if (pcnt_q != POLL_MAX) pcnt_d = pcnt_q + 16'd1;
          tmr_d   = 16'd0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (tmr_q == AH_LAST) begin
          tmr_d   = 16'd0;
          state_d = RECOVER;
        end
      end
      RECOVER: begin
        if (tmr_q == EL_LAST) begin
          tmr_d = 16'd0;
          if (poll_q && rdata_q[7] && (pcnt_q < POLL_MAX)) begin
            state_d = SETUP;
          end else begin
            state_d   = IDLE;
            done_d    = 1'b1;
            timeout_d = poll_q & rdata_q[7] & (pcnt_q == POLL_MAX);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Pin drivers are registered from the next state so they change cleanly on the clock edge.
    active_d = (state_d != IDLE);
    e_d      = (state_d == EHIGH);
    lrs_d    = active_d & rs_d;
    rw_d     = active_d;
  end

  always_ff @(posedge clkIn) begin
    if (!rstIn_n) begin
      state_q   <= IDLE;
      tmr_q     <= 16'd0;
      pcnt_q    <= 16'd0;
      rs_q      <= 1'b0;
      poll_q    <= 1'b0;
      rdata_q   <= 8'h00;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      e_q       <= 1'b0;
      lrs_q     <= 1'b0;
      rw_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      pcnt_q    <= pcnt_d;
      rs_q      <= rs_d;
      poll_q    <= poll_d;
      rdata_q   <= rdata_d;
      active_q  <= active_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      e_q       <= e_d;
      lrs_q     <= lrs_d;
      rw_q      <= rw_d;
    end
  end

  assign active  = active_q;
  assign done    = done_q;
  assign timeout = timeout_q;
  assign rdata   = rdata_q;
  assign lcd_e   = e_q;
  assign lcd_rs  = lrs_q;
  assign lcd_rw  = rw_q;

endmodule

// File: tb/tb_hd44780_rd.sv
// tb/tb_hd44780_rd.sv - directed bench for hd44780_rd (default DUT plus a POLL_MAX=4 instance)
module tb_hd44780_rd;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_a, rs_a, poll_a, req_b, rs_b, poll_b;
  logic [7:0] db_a, db_b;
  logic       act_a, done_a, to_a, e_a, lrs_a, rw_a;
  logic       act_b, done_b, to_b, e_b, lrs_b, rw_b;
  logic [7:0] rdata_a, rdata_b;
  logic       sel;
  logic       m_e, m_done, m_to, m_rs, m_rw;

  int n_chk = 0;
  int n_fail = 0;

  always #10 clk = ~clk;

  hd44780_rd dut (
    .clkIn(clk), .rstIn_n(rst_n), .req(req_a), .rs_sel(rs_a), .poll(poll_a),
    .active(act_a), .done(done_a), .timeout(to_a), .rdata(rdata_a),
    .lcd_e(e_a), .lcd_rs(lrs_a), .lcd_rw(rw_a), .lcd_db_in(db_a)
  );

  hd44780_rd #(.POLL_MAX(16'd4)) dut4 (
    .clkIn(clk), .rstIn_n(rst_n), .req(req_b), .rs_sel(rs_b), .poll(poll_b),
    .active(act_b), .done(done_b), .timeout(to_b), .rdata(rdata_b),
    .lcd_e(e_b), .lcd_rs(lrs_b), .lcd_rw(rw_b), .lcd_db_in(db_b)
  );

  assign m_e    = sel ? e_b    : e_a;
  assign m_done = sel ? done_b : done_a;
  assign m_to   = sel ? to_b   : to_a;
  assign m_rs   = sel ? lrs_b  : lrs_a;
  assign m_rw   = sel ? rw_b   : rw_a;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic r, input logic [7:0] d);
    if (sel) begin req_b = r; db_b = d; end
    else     begin req_a = r; db_a = d; end
  endtask

  // Cycle 0 is the cycle in which req is presented; returns in the done cycle.
  task automatic run_txn(input int ext, input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                         output int rises, output int first, output int hi_cnt, output int done_cyc,
                         output logic to_at_done, output logic rs1, output logic rw1);
    int   cyc;
    logic pe;
    rises = 0; first = -1; hi_cnt = 0; done_cyc = -1;
    to_at_done = 1'b0; rs1 = 1'b0; rw1 = 1'b0; pe = 1'b0; cyc = 0;
    while (cyc < 2000 && done_cyc < 0) begin
      drive((cyc == 0) || (cyc == ext), (rises <= 1) ? d0 : (rises == 2) ? d1 : d2);
      step();
      cyc++;
      if (m_e && !pe) begin
        rises++;
        if (first < 0) first = cyc;
      end
      if (m_e) hi_cnt++;
      pe = m_e;
      if (cyc == 1) begin rs1 = m_rs; rw1 = m_rw; end
      if (m_done) begin done_cyc = cyc; to_at_done = m_to; end
    end
  endtask

  int   rises, first, hi_cnt, done_cyc, cnt;
  logic to_d, rs1, rw1;

  initial begin
    sel = 1'b0;
    rst_n = 1'b0;
    req_a = 0; rs_a = 0; poll_a = 0; db_a = 8'h00;
    req_b = 0; rs_b = 0; poll_b = 0; db_b = 8'h00;
    step(); step(); step();
    check("rst_active", 32'(act_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_timeout", 32'(to_a), 32'd0);
    check("rst_rdata", 32'(rdata_a), 32'h00);
    check("rst_lcd_e", 32'(e_a), 32'd0);
    check("rst_lcd_rs", 32'(lrs_a), 32'd0);
    check("rst_lcd_rw", 32'(rw_a), 32'd0);
    rst_n = 1'b1;
    step();

    // Reset in the middle of EHIGH
    rs_a = 1'b1; db_a = 8'h41; req_a = 1'b1;
    step();
    req_a = 1'b0;
    for (int i = 0; i < 9; i++) step();
    check("midreset_e_before", 32'(e_a), 32'd1);
    rst_n = 1'b0;
    step();
    check("midreset_e", 32'(e_a), 32'd0);
    check("midreset_active", 32'(act_a), 32'd0);
    check("midreset_done", 32'(done_a), 32'd0);
    check("midreset_rdata", 32'(rdata_a), 32'h00);
    step(); step();
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (done_a || e_a || act_a) cnt++;
    end
    check("midreset_quiet_after", 32'(cnt), 32'd0);

    // Single data read
    rs_a = 1'b1; poll_a = 1'b0;
    run_txn(-1, 8'h41, 8'h41, 8'h41, rises, first, hi_cnt, done_cyc, to_d, rs1, rw1);
    check("single_rs_c1", 32'(rs1), 32'd1);
    check("single_rw_c1", 32'(rw1), 32'd1);
    check("single_e_rise", 32'(first), 32'd4);
    check("single_e_width", 32'(hi_cnt), 32'd25);
    check("single_e_pulses", 32'(rises), 32'd1);
    check("single_done_cyc", 32'(done_cyc), 32'd54);
    check("single_rdata", 32'(rdata_a), 32'h41);
    check("single_timeout", 32'(to_d), 32'd0);
    check("single_idle_active", 32'(act_a), 32'd0);
    check("single_idle_rs", 32'(lrs_a), 32'd0);
    check("single_idle_rw", 32'(rw_a), 32'd0);
    step();
    check("single_done_one_cycle", 32'(done_a), 32'd0);

    // Busy-flag poll clearing on the third read
    rs_a = 1'b0; poll_a = 1'b1;
    run_txn(-1, 8'h8A, 8'h93, 8'h05, rises, first, hi_cnt, done_cyc, to_d, rs1, rw1);
    check("poll_rs_c1", 32'(rs1), 32'd0);
    check("poll_e_pulses", 32'(rises), 32'd3);
    check("poll_e_high_total", 32'(hi_cnt), 32'd75);
    check("poll_done_cyc", 32'(done_cyc), 32'd160);
    check("poll_rdata", 32'(rdata_a), 32'h05);
    check("poll_timeout", 32'(to_d), 32'd0);
    step();

    // Request collisions: req at cycle 10 and on the done cycle are ignored
    rs_a = 1'b1; poll_a = 1'b0;
    run_txn(10, 8'h41, 8'h41, 8'h41, rises, first, hi_cnt, done_cyc, to_d, rs1, rw1);
    check("collide_e_pulses", 32'(rises), 32'd1);
    check("collide_done_cyc", 32'(done_cyc), 32'd54);
    req_a = 1'b1;
    step();
    check("collide_done_req_ignored", 32'(act_a), 32'd0);
    run_txn(-1, 8'h41, 8'h41, 8'h41, rises, first, hi_cnt, done_cyc, to_d, rs1, rw1);
    check("collide_next_e_rise", 32'(first + 55), 32'd59);
    check("collide_next_done", 32'(done_cyc), 32'd54);
    step();

    // poll with rs_sel=1 is a single data read
    rs_a = 1'b1; poll_a = 1'b1;
    run_txn(-1, 8'hFF, 8'hFF, 8'hFF, rises, first, hi_cnt, done_cyc, to_d, rs1, rw1);
    check("pollrs1_e_pulses", 32'(rises), 32'd1);
    check("pollrs1_done_cyc", 32'(done_cyc), 32'd54);
    check("pollrs1_timeout", 32'(to_d), 32'd0);
    check("pollrs1_rdata", 32'(rdata_a), 32'hFF);
    step();

    // Poll limit exhausted on the POLL_MAX=4 instance
    sel = 1'b1; rs_b = 1'b0; poll_b = 1'b1;
    run_txn(-1, 8'h80, 8'h80, 8'h80, rises, first, hi_cnt, done_cyc, to_d, rs1, rw1);
    check("timeout_e_pulses", 32'(rises), 32'd4);
    check("timeout_e_high_total", 32'(hi_cnt), 32'd100);
    check("timeout_done_cyc", 32'(done_cyc), 32'd213);
    check("timeout_flag", 32'(to_d), 32'd1);
    check("timeout_rdata", 32'(rdata_b), 32'h80);
    step();
    check("timeout_one_cycle", 32'(to_b), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
